sd_emmc_clk_gen: RTL and testbench

SD_EMMC_CLK_GEN -- requirements
Module: sd_emmc_clk_gen

---
 rtl/sd_emmc_clk_gen_pkg.sv | 13 +
 rtl/sd_emmc_clk_gen_lock_mon.sv | 33 +++
 rtl/sd_emmc_clk_gen.sv | 114 +++++++++++
 tb/tb_sd_emmc_clk_gen.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/sd_emmc_clk_gen_pkg.sv
// Shared FSM encoding and default sizing for the SD/eMMC clock generator.
// Pure declarations; no timing or flow control.
package sd_emmc_clk_gen_pkg;

    localparam int DEF_DIV_W      = 16;
    localparam int DEF_LOCK_EDGES = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/sd_emmc_clk_gen_lock_mon.sv
// Lock monitor: counts sd_clk rising edges since the last divisor change; saturates at LOCK_EDGES.
// locked follows the registered count (same cycle as the counting edge); no backpressure.
module sd_emmc_lock_mon
    import sd_emmc_clk_gen_pkg::*;
#(
    parameter int LOCK_EDGES = DEF_LOCK_EDGES
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic rise,
    output logic locked
);

    localparam int CW = $clog2(LOCK_EDGES + 1);
    localparam logic [CW-1:0] FULL = CW'(LOCK_EDGES);

    logic [CW-1:0] edge_cnt;

    // A rise coinciding with a clear is the first edge at the new divisor.
    always_ff @(posedge clk) begin
        if (rst) begin
            edge_cnt <= '0;
        end else if (clear) begin
            edge_cnt <= rise ? CW'(1) : '0;
        end else if (rise && (edge_cnt != FULL)) begin
            edge_cnt <= edge_cnt + CW'(1);
        end
    end

    assign locked = (edge_cnt == FULL);

endmodule

// File: rtl/sd_emmc_clk_gen.sv
// Glitch-free programmable SD/eMMC clock divider with 90-degree copy, edge strobes and lock flag.
// Outputs registered; sd_clk rises one clk after clk_en seen in IDLE; no backpressure.
module sd_emmc_clk_gen
    import sd_emmc_clk_gen_pkg::*;
#(
    parameter int DIV_W      = DEF_DIV_W,
    parameter int LOCK_EDGES = DEF_LOCK_EDGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] divisor,
    input  logic             clk_en,
    output logic             sd_clk,
    output logic             sd_clk_90,
    output logic             pos_stb,
    output logic             neg_stb,
    output logic             running,
    output logic             locked
);

    state_t            state, state_nxt;
    logic [DIV_W-1:0]  divisor_q;
    logic [DIV_W-1:0]  divisor_act, act_nxt;
    logic [DIV_W-1:0]  cnt, cnt_nxt;
    logic              sd_nxt, sd90_nxt, pos_nxt, neg_nxt;
    logic              rise, stop, lock_clear;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            divisor_q   <= '0;
            divisor_act <= '0;
            cnt         <= '0;
            sd_clk      <= 1'b0;
            sd_clk_90   <= 1'b0;
            pos_stb     <= 1'b0;
            neg_stb     <= 1'b0;
        end else begin
            state       <= state_nxt;
            divisor_q   <= divisor;
            divisor_act <= act_nxt;
            cnt         <= cnt_nxt;
            sd_clk      <= sd_nxt;
            sd_clk_90   <= sd90_nxt;
            pos_stb     <= pos_nxt;
            neg_stb     <= neg_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        act_nxt   = divisor_act;
        cnt_nxt   = cnt;
        sd_nxt    = sd_clk;
        sd90_nxt  = sd_clk_90;
        pos_nxt   = 1'b0;
        neg_nxt   = 1'b0;
        rise      = 1'b0;
        stop      = 1'b0;
        case (state)
            ST_IDLE: begin
                cnt_nxt  = '0;
                sd_nxt   = 1'b0;
                sd90_nxt = 1'b0;
                if (clk_en) begin
                    act_nxt   = divisor_q;
                    sd_nxt    = 1'b1;
                    pos_nxt   = 1'b1;
                    rise      = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (cnt == (divisor_act >> 1)) begin
                    sd90_nxt = ~sd_clk_90;
                end
                if (cnt == divisor_act) begin
                    cnt_nxt = '0;
                    if (sd_clk) begin
                        sd_nxt  = 1'b0;
                        neg_nxt = 1'b1;
                    end else if (clk_en) begin
                        // Divisor only switches at a rising edge so no half is ever shortened.
                        act_nxt = divisor_q;
                        sd_nxt  = 1'b1;
                        pos_nxt = 1'b1;
                        rise    = 1'b1;
                    end else begin
                        sd90_nxt  = 1'b0;
                        stop      = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end else begin
                    cnt_nxt = cnt + DIV_W'(1);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign running    = (state == ST_RUN);
    assign lock_clear = (state == ST_IDLE) || stop || (act_nxt != divisor_act);

    sd_emmc_lock_mon #(
        .LOCK_EDGES (LOCK_EDGES)
    ) u_lock_mon (
        .clk    (clk),
        .rst    (rst),
        .clear  (lock_clear),
        .rise   (rise),
        .locked (locked)
    );

endmodule

// File: tb/tb_sd_emmc_clk_gen.sv
// Directed bench for sd_emmc_clk_gen: divide-by patterns, live divisor switch, stop, reset, max divisor.
// Cycle k counts posedges since the edge that first raises sd_clk; samples taken 1ns after each edge.
module tb_sd_emmc_clk_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] divisor;
    logic        clk_en;
    logic        sd_clk, sd_clk_90, pos_stb, neg_stb, running, locked;

    int tests  = 0;
    int failed = 0;

    sd_emmc_clk_gen dut (
        .clk       (clk),
        .rst       (rst),
        .divisor   (divisor),
        .clk_en    (clk_en),
        .sd_clk    (sd_clk),
        .sd_clk_90 (sd_clk_90),
        .pos_stb   (pos_stb),
        .neg_stb   (neg_stb),
        .running   (running),
        .locked    (locked)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Hand-derived waveform for the div 3 -> 9 -> 5 scenario:
    // div3 halves of 4 (k 1..72), div9 halves of 10 (k 73..232), div5 high 233..238, low 239..244, then stopped.
    function automatic logic exp_sd(input int k);
        if (k < 1)        return 1'b0;
        else if (k <= 72)  return (((k - 1) / 4) % 2) == 0;
        else if (k <= 232) return (((k - 73) / 10) % 2) == 0;
        else if (k <= 244) return k <= 238;
        else               return 1'b0;
    endfunction

    // Lag 2 at div3, 5 at div9, 3 at div5; low while the new half's toggle point has not been reached.
    function automatic logic exp_90(input int k);
        if (k <= 72)       return exp_sd(k - 2);
        else if (k <= 77)  return 1'b0;
        else if (k <= 232) return exp_sd(k - 5);
        else if (k <= 235) return 1'b0;
        else if (k <= 244) return exp_sd(k - 3);
        else               return 1'b0;
    endfunction

    function automatic logic exp_lock(input int k);
        return (k >= 57 && k < 73) || (k >= 213 && k < 233);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        rst     = 1'b1;
        clk_en  = 1'b0;
        divisor = 16'd0;
        tick();
        tick();
        chk("rst_sd_clk",  {31'd0, sd_clk},    32'd0);
        chk("rst_sd_90",   {31'd0, sd_clk_90}, 32'd0);
        chk("rst_pos",     {31'd0, pos_stb},   32'd0);
        chk("rst_neg",     {31'd0, neg_stb},   32'd0);
        chk("rst_running", {31'd0, running},   32'd0);
        chk("rst_locked",  {31'd0, locked},    32'd0);

        // divisor 0: period 2, sd_clk_90 = ~sd_clk, lock at the 8th rise (k=15)
        rst = 1'b0;
        tick();
        chk("idle_sd_clk", {31'd0, sd_clk}, 32'd0);
        clk_en = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            tick();
            chk("d0_sd_clk", {31'd0, sd_clk},    {31'd0, k[0]});
            chk("d0_sd_90",  {31'd0, sd_clk_90}, {31'd0, ~k[0]});
            chk("d0_pos",    {31'd0, pos_stb},   {31'd0, k[0]});
            chk("d0_neg",    {31'd0, neg_stb},   {31'd0, ~k[0]});
            chk("d0_locked", {31'd0, locked},    {31'd0, (k >= 15)});
        end

        // reset while running and locked
        rst = 1'b1;
        tick();
        chk("mid_rst_sd_clk",  {31'd0, sd_clk},    32'd0);
        chk("mid_rst_sd_90",   {31'd0, sd_clk_90}, 32'd0);
        chk("mid_rst_pos",     {31'd0, pos_stb},   32'd0);
        chk("mid_rst_neg",     {31'd0, neg_stb},   32'd0);
        chk("mid_rst_running", {31'd0, running},   32'd0);
        chk("mid_rst_locked",  {31'd0, locked},    32'd0);

        // restart at divisor 3, switch to 9 mid-high, glitch on clk_en in a low half, then stop at divisor 5
        rst     = 1'b0;
        clk_en  = 1'b0;
        divisor = 16'd3;
        tick();
        clk_en = 1'b1;
        for (int k = 1; k <= 250; k++) begin
            tick();
            chk("seq_sd_clk",  {31'd0, sd_clk},    {31'd0, exp_sd(k)});
            chk("seq_sd_90",   {31'd0, sd_clk_90}, {31'd0, exp_90(k)});
            chk("seq_pos",     {31'd0, pos_stb},   {31'd0, exp_sd(k) && !exp_sd(k - 1)});
            chk("seq_neg",     {31'd0, neg_stb},   {31'd0, !exp_sd(k) && exp_sd(k - 1)});
            chk("seq_locked",  {31'd0, locked},    {31'd0, exp_lock(k)});
            chk("seq_running", {31'd0, running},   {31'd0, (k < 245)});
            if (k == 66)  divisor = 16'd9;
            if (k == 224) clk_en  = 1'b0;
            if (k == 225) divisor = 16'd5;
            if (k == 228) clk_en  = 1'b1;
            if (k == 235) clk_en  = 1'b0;
        end

        // maximum divisor: one high half must last exactly 65536 clk
        divisor = 16'hFFFF;
        tick();
        clk_en = 1'b1;
        tick();
        chk("max_first_high", {31'd0, sd_clk}, 32'd1);
        n = 1;
        for (int i = 0; i < 70000; i++) begin
            tick();
            if (sd_clk !== 1'b1) break;
            n++;
        end
        chk("max_half_len", n, 32'd65536);
        chk("max_neg_stb", {31'd0, neg_stb}, 32'd1);
        chk("max_running", {31'd0, running}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
